// File: rtl/paddle_encoder.sv
// Rotary-encoder paddle front end: synchronises and debounces the quadrature pins,
// decodes Gray-code edges into clamped position steps, and counts illegal transitions.
module paddle_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 250,
   parameter int unsigned STEP            = 4,
   parameter int unsigned POS_MAX         = 508,
   parameter int unsigned POS_INIT        = 256
) (
   input  logic       clk25,
   input  logic       resetn,
   input  logic       rota,
   input  logic       rotb,
   output logic [8:0] paddlePosition,
   output logic       moved,
   output logic       dir,
   output logic [7:0] errCount
);

   localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [9:0]  STEP_W    = 10'(STEP);
   localparam logic [9:0]  POS_MAX_W = 10'(POS_MAX);
   localparam logic [8:0]  POS_MAX_9 = 9'(POS_MAX);
   localparam logic [8:0]  POS_INIT_9 = 9'(POS_INIT);

   typedef enum logic [1:0] {
      EDGE_NONE,
      EDGE_INC,
      EDGE_DEC,
      EDGE_ILLEGAL
   } edge_e;

   logic [1:0]       syncA_q, syncB_q;
   logic [1:0]       synced;
   logic [1:0]       stable_q, stable_d;
   logic [1:0][15:0] cnt_q, cnt_d;
   logic [1:0]       prev_q;
   logic [8:0]       pos_q, pos_d;
   logic             moved_q, moved_d;
   logic             dir_q, dir_d;
   logic [7:0]       err_q, err_d;
   edge_e            edgeKind;
   logic [9:0]       posWide, posSum, posDiff;

   // Bit 1 is channel A, bit 0 is channel B throughout.
   assign synced = {syncA_q[1], syncB_q[1]};

   // A change is accepted only after the synced pin has differed for DEBOUNCE_CYCLES cycles in a row.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int ch = 0; ch < 2; ch++) begin
         if (synced[ch] == stable_q[ch]) begin
            cnt_d[ch] = '0;
         end else if (cnt_q[ch] == DB_LAST) begin
            stable_d[ch] = synced[ch];
            cnt_d[ch]    = '0;
         end else begin
            cnt_d[ch] = cnt_q[ch] + 16'd1;
         end
      end
   end

   always_comb begin
      edgeKind = EDGE_NONE;
      case ({prev_q, stable_q})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: edgeKind = EDGE_INC;
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: edgeKind = EDGE_DEC;
         default: begin
            if (prev_q != stable_q) begin
               edgeKind = EDGE_ILLEGAL;
            end
         end
      endcase
   end

   // Widened to 10 bits so the clamp comparisons see true sums without wrapping.
   assign posWide = {1'b0, pos_q};
   assign posSum  = posWide + STEP_W;
   assign posDiff = posWide - STEP_W;

   always_comb begin
      pos_d   = pos_q;
      moved_d = 1'b0;
      dir_d   = dir_q;
      err_d   = err_q;
      case (edgeKind)
         EDGE_INC: begin
            moved_d = 1'b1;
            dir_d   = 1'b1;
            pos_d   = (posSum > POS_MAX_W) ? POS_MAX_9 : posSum[8:0];
         end
         EDGE_DEC: begin
            moved_d = 1'b1;
            dir_d   = 1'b0;
            pos_d   = (posWide < STEP_W) ? 9'd0 : posDiff[8:0];
         end
         EDGE_ILLEGAL: begin
            if (err_q != 8'hFF) begin
               err_d = err_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk25 or negedge resetn) begin
      if (!resetn) begin
         syncA_q  <= 2'b11;
         syncB_q  <= 2'b11;
         stable_q <= 2'b11;
         cnt_q    <= '0;
         prev_q   <= 2'b11;
         pos_q    <= POS_INIT_9;
         moved_q  <= 1'b0;
         dir_q    <= 1'b1;
         err_q    <= 8'd0;
      end else begin
         syncA_q  <= {syncA_q[0], rota};
         syncB_q  <= {syncB_q[0], rotb};
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         prev_q   <= stable_q;
         pos_q    <= pos_d;
         moved_q  <= moved_d;
         dir_q    <= dir_d;
         err_q    <= err_d;
      end
   end

   assign paddlePosition = pos_q;
   assign moved          = moved_q;
   assign dir            = dir_q;
   assign errCount       = err_q;

endmodule

// File: tb/tb_paddle_encoder.sv
// Self-checking bench for paddle_encoder: randomized quadrature walks with bounce,
// checked against a sequence-position model of the encoder and its clamped position.
module tb_paddle_encoder;

   localparam int DB    = 16;
   localparam int STEP  = 4;
   localparam int PMAX  = 508;
   localparam int PINIT = 256;

   logic       clk25  = 1'b0;
   logic       resetn = 1'b0;
   logic       rota   = 1'b1;
   logic       rotb   = 1'b1;
   logic [8:0] paddlePosition;
   logic       moved;
   logic       dir;
   logic [7:0] errCount;

   int checks   = 0;
   int failures = 0;

   int         modelPos;
   int         modelDir;
   int         modelErr;
   logic [1:0] modelAb;
   logic [1:0] incSeq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   paddle_encoder #(
      .DEBOUNCE_CYCLES(DB),
      .STEP(STEP),
      .POS_MAX(PMAX),
      .POS_INIT(PINIT)
   ) dut (
      .clk25(clk25),
      .resetn(resetn),
      .rota(rota),
      .rotb(rotb),
      .paddlePosition(paddlePosition),
      .moved(moved),
      .dir(dir),
      .errCount(errCount)
   );

   always #20 clk25 = ~clk25;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int seqIndex(input logic [1:0] code);
      int idx = 0;
      for (int i = 0; i < 4; i++) begin
         if (incSeq[i] == code) idx = i;
      end
      return idx;
   endfunction

   // Step count is the distance travelled around the increment cycle: +1 inc, -1 dec, 2 illegal.
   task automatic modelEdge(input logic [1:0] newAb, output int expPulses);
      int d;
      expPulses = 0;
      d = (seqIndex(newAb) - seqIndex(modelAb) + 4) % 4;
      if (d == 1) begin
         modelPos  = (modelPos + STEP > PMAX) ? PMAX : modelPos + STEP;
         modelDir  = 1;
         expPulses = 1;
      end else if (d == 3) begin
         modelPos  = (modelPos < STEP) ? 0 : modelPos - STEP;
         modelDir  = 0;
         expPulses = 1;
      end else if (d == 2) begin
         modelErr = (modelErr < 255) ? modelErr + 1 : 255;
      end
      modelAb = newAb;
   endtask

   task automatic modelReset();
      modelPos = PINIT;
      modelDir = 1;
      modelErr = 0;
      modelAb  = 2'b11;
   endtask

   task automatic waitCycles(input int n, output int pulses, output int firstAt);
      pulses  = 0;
      firstAt = -1;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk25);
         if (moved === 1'b1) begin
            pulses++;
            if (firstAt < 0) firstAt = c;
         end
      end
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, " pos"}, 32'(paddlePosition), 32'(modelPos));
      checkOutput({tag, " dir"}, 32'(dir), 32'(modelDir));
      checkOutput({tag, " err"}, 32'(errCount), 32'(modelErr));
   endtask

   // Optional bounce: short excursions to the new code that never last long enough to be accepted.
   task automatic applyStimulus(input logic [1:0] newAb, input bit doBounce, input string tag);
      logic [1:0] oldAb;
      int bouncePulses, p, f, expPulses, nBounce;
      oldAb        = {rota, rotb};
      bouncePulses = 0;
      if (doBounce) begin
         nBounce = $urandom_range(1, 4);
         for (int i = 0; i < nBounce; i++) begin
            {rota, rotb} = newAb;
            waitCycles($urandom_range(1, DB - 4), p, f);
            bouncePulses += p;
            {rota, rotb} = oldAb;
            waitCycles($urandom_range(1, DB - 4), p, f);
            bouncePulses += p;
         end
      end
      {rota, rotb} = newAb;
      modelEdge(newAb, expPulses);
      waitCycles(DB + 10, p, f);
      checkOutput({tag, " bounce pulses"}, 32'(bouncePulses), 32'd0);
      checkOutput({tag, " pulses"}, 32'(p), 32'(expPulses));
      if (expPulses == 1) checkOutput({tag, " latency"}, 32'(f), 32'(DB + 3));
      checkState(tag);
   endtask

   function automatic logic [1:0] nextCode(input logic [1:0] cur, input bit up);
      return up ? incSeq[(seqIndex(cur) + 1) % 4] : incSeq[(seqIndex(cur) + 3) % 4];
   endfunction

   initial begin
      int p, f, r;
      modelReset();

      // Reset values and a long quiet period with pins at rest.
      repeat (5) @(negedge clk25);
      checkState("in reset");
      checkOutput("in reset moved", 32'(moved), 32'd0);
      resetn = 1'b1;
      waitCycles(1000, p, f);
      checkOutput("quiet pulses", 32'(p), 32'd0);
      checkState("quiet");

      // Reset in the middle of a debounce; the pin is still low afterwards so the edge reappears.
      rota = 1'b0;
      waitCycles(DB / 2, p, f);
      checkOutput("pre-reset pulses", 32'(p), 32'd0);
      resetn = 1'b0;
      waitCycles(3, p, f);
      resetn = 1'b1;
      modelReset();
      checkState("after mid reset");
      checkOutput("after mid reset moved", 32'(moved), 32'd0);
      modelEdge(2'b01, r);
      waitCycles(DB + 10, p, f);
      checkOutput("mid reset pulses", 32'(p), 32'(r));
      checkOutput("mid reset latency", 32'(f), 32'(DB + 3));
      checkState("mid reset");

      for (int i = 0; i < 70; i++) applyStimulus(nextCode(modelAb, 1'b1), 1'($urandom_range(0, 1)), "up walk");
      checkOutput("top clamp", 32'(paddlePosition), 32'(PMAX));

      for (int i = 0; i < 140; i++) applyStimulus(nextCode(modelAb, 1'b0), 1'($urandom_range(0, 1)), "down walk");
      checkOutput("bottom clamp", 32'(paddlePosition), 32'd0);

      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) applyStimulus(~modelAb, 1'b0, "mixed illegal");
         else applyStimulus(nextCode(modelAb, r < 5), 1'($urandom_range(0, 1)), "mixed legal");
      end

      for (int i = 0; i < 300; i++) applyStimulus(~modelAb, 1'b0, "illegal run");
      checkOutput("err saturated", 32'(errCount), 32'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
